seq_cmp_controller: RTL and testbench

//  Sequences a bit-serial unsigned magnitude comparison of two WIDTH-bit operands.
//  - Loads both operands into MSB-first shift registers and walks them one bit per clock.
//  - Reports gt/eq/lt through a start/done handshake.
//  - Sits between the register file / test harness and the serial comparator datapath; owns all of its sequencing.

---
 rtl/seq_cmp_controller_pkg.sv | 5 +
 rtl/seq_cmp_controller_msb_shifter.sv | 20 ++
 rtl/seq_cmp_controller.sv | 66 ++++++
 tb/tb_seq_cmp_controller.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/seq_cmp_controller_pkg.sv
// seq_cmp_controller_pkg: shared state encoding and default operand width
package seq_cmp_controller_pkg;
   localparam int DEF_WIDTH = 32;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FINISH = 2'd2} state_t;
endpackage

// File: rtl/seq_cmp_controller_msb_shifter.sv
// seq_cmp_controller_msb_shifter: loadable left-shift register exposing its MSB
module seq_cmp_controller_msb_shifter
   import seq_cmp_controller_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] d,
   output logic             msb
);
   logic [WIDTH-1:0] q;
   always_ff @(posedge clk or posedge reset)
      if (reset) q <= '0;
      else if (load) q <= d;
      else if (shift) q <= {q[WIDTH-2:0], 1'b0};
   assign msb = q[WIDTH-1];
endmodule

// File: rtl/seq_cmp_controller.sv
// seq_cmp_controller: bit-serial MSB-first unsigned compare with start/done handshake
module seq_cmp_controller
   import seq_cmp_controller_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       abort,
   input  logic [WIDTH-1:0]           a_in,
   input  logic [WIDTH-1:0]           b_in,
   output logic                       busy,
   output logic                       done,
   output logic                       gt,
   output logic                       eq,
   output logic                       lt,
   output logic [$clog2(WIDTH+1)-1:0] nbits
);
   localparam int CW = $clog2(WIDTH + 1);
   state_t state, state_n;
   logic [CW-1:0] cnt;
   logic bit_a, bit_b, load, kill, run, diff, last;
   seq_cmp_controller_msb_shifter #(.WIDTH(WIDTH)) u_a (
      .clk(clk), .reset(reset), .load(load), .shift(run), .d(a_in), .msb(bit_a)
   );
   seq_cmp_controller_msb_shifter #(.WIDTH(WIDTH)) u_b (
      .clk(clk), .reset(reset), .load(load), .shift(run), .d(b_in), .msb(bit_b)
   );
   always_comb begin
      load = state == IDLE && start && !abort;
      kill = state != IDLE && abort;
      run = state == RUN && !abort;
      diff = bit_a != bit_b;
      last = cnt == CW'(1);
      state_n = kill ? IDLE
              : load ? RUN
              : (run && (last || (EARLY_EXIT && diff))) ? FINISH
              : state == FINISH ? IDLE
              : state;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_n;
   // gt|lt doubles as the sticky "already decided" flag
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         cnt <= '0;
         nbits <= '0;
         {gt, eq, lt} <= '0;
      end else if (load) begin
         cnt <= CW'(WIDTH);
         nbits <= '0;
         {gt, eq, lt} <= '0;
      end else if (kill) begin
         {gt, eq, lt} <= '0;
      end else if (run) begin
         cnt <= cnt - CW'(1);
         nbits <= nbits + CW'(1);
         if (!gt && !lt && diff) {gt, lt} <= {bit_a, bit_b};
         if (last && !gt && !lt && !diff) eq <= 1'b1;
      end
   assign busy = state != IDLE;
   assign done = state == FINISH && !abort;
endmodule

// File: tb/tb_seq_cmp_controller.sv
// tb_seq_cmp_controller: both EARLY_EXIT variants checked cycle by cycle against a timeline model
module tb_seq_cmp_controller;
   localparam int W = 32;
   logic clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0;
   logic [W-1:0] a_in = '0, b_in = '0;
   logic [1:0] bsy, dn, g, q, l;
   logic [5:0] nb [2];
   int tests = 0, fails = 0;
   int act [2], e [2], k [2], fd [2], rnb [2];
   logic cg [2], cl [2], rg [2], rl [2], rq [2];

   seq_cmp_controller #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut0 (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .a_in(a_in), .b_in(b_in),
      .busy(bsy[0]), .done(dn[0]), .gt(g[0]), .eq(q[0]), .lt(l[0]), .nbits(nb[0])
   );
   seq_cmp_controller #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut1 (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .a_in(a_in), .b_in(b_in),
      .busy(bsy[1]), .done(dn[1]), .gt(g[1]), .eq(q[1]), .lt(l[1]), .nbits(nb[1])
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   // index (1 = MSB) of the first differing bit, 0 when equal
   function automatic int first_diff(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [63:0] x;
      x = {32'd0, a ^ b};
      return (x == 0) ? 0 : W + 1 - $clog2(x + 64'd1);
   endfunction

   // Compare against the model, then advance the model with the inputs the next edge will sample
   always @(negedge clk) begin
      for (int c = 0; c < 2; c++) begin : cmp
         logic be, de, ge, qe, le;
         logic [5:0] nbe;
         if (reset) begin
            {be, de, ge, qe, le} = '0;
            nbe = '0;
         end else if (act[c] != 0) begin
            be = 1'b1;
            de = (e[c] == k[c]) && !abort;
            nbe = 6'(e[c]);
            ge = cg[c] && fd[c] != 0 && e[c] >= fd[c];
            le = cl[c] && fd[c] != 0 && e[c] >= fd[c];
            qe = fd[c] == 0 && e[c] == W;
         end else begin
            {be, de} = '0;
            {ge, qe, le} = {rg[c], rq[c], rl[c]};
            nbe = 6'(rnb[c]);
         end
         chk($sformatf("busy%0d", c), bsy[c], be);
         chk($sformatf("done%0d", c), dn[c], de);
         chk($sformatf("gt%0d", c), g[c], ge);
         chk($sformatf("eq%0d", c), q[c], qe);
         chk($sformatf("lt%0d", c), l[c], le);
         chk($sformatf("nbits%0d", c), nb[c], nbe);
      end
      for (int c = 0; c < 2; c++) begin
         if (reset) begin
            act[c] = 0; e[c] = 0; rnb[c] = 0;
            {rg[c], rq[c], rl[c]} = '0;
         end else if (act[c] != 0) begin
            if (abort) begin
               act[c] = 0; rnb[c] = e[c];
               {rg[c], rq[c], rl[c]} = '0;
            end else if (e[c] == k[c]) begin
               act[c] = 0; rnb[c] = k[c];
               {rg[c], rq[c], rl[c]} = {cg[c], fd[c] == 0, cl[c]};
            end else e[c]++;
         end else if (start && !abort) begin
            act[c] = 1; e[c] = 0;
            fd[c] = first_diff(a_in, b_in);
            cg[c] = a_in > b_in;
            cl[c] = a_in < b_in;
            k[c] = (c == 1 && fd[c] != 0) ? fd[c] : W;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      start = 1'b0;
      abort = 1'b0;
      repeat (n) tick();
   endtask

   // cyc counts cycles after the accept edge: done in cycle N+k+1 gives cyc = k+1
   task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input int c,
                     input int lat, input int nbe, input logic [2:0] res, input string nm);
      int cyc;
      start = 1'b1; a_in = a; b_in = b;
      tick();
      start = 1'b0;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!dn[c] && cyc < 100);
      chk({nm, " latency"}, cyc, lat);
      chk({nm, " nbits"}, nb[c], nbe);
      chk({nm, " gt/eq/lt"}, {g[c], q[c], l[c]}, res);
      idle(40);
   endtask

   initial begin
      int n;
      logic [2:0] r;
      #1 reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("reset busy", bsy, 0);
      chk("reset done", dn, 0);
      chk("reset gt/eq/lt", {g, q, l}, 0);
      chk("reset nbits", {nb[1], nb[0]}, 0);
      tick();
      op(32'hFFFF_0000, 32'h7FFF_FFFF, 1, 2, 1, 3'b100, "t1");
      op(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 33, 32, 3'b010, "t2");
      op(32'h0000_0004, 32'h0000_0005, 0, 33, 32, 3'b001, "t3");
      // second start while busy must be ignored
      start = 1'b1; a_in = 32'd5; b_in = 32'd3;
      tick();
      start = 1'b0;
      n = 0;
      r = '0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         n += int'(dn[1]);
         if (dn[1]) r = {g[1], q[1], l[1]};
         tick();
         start = (i == 4);
         a_in = '0;
         b_in = '1;
      end
      chk("t4 done pulses", n, 1);
      chk("t4 result", r, 3'b100);
      chk("t4 nbits", nb[1], 30);
      idle(10);
      // abort at cycle 10 of an equal compare
      start = 1'b1; a_in = 32'h1234_5678; b_in = 32'h1234_5678;
      tick();
      start = 1'b0;
      repeat (9) tick();
      abort = 1'b1;
      @(negedge clk);
      chk("t5 done in abort cycle", dn, 0);
      tick();
      abort = 1'b0;
      @(negedge clk);
      chk("t5 busy", bsy, 0);
      chk("t5 gt/eq/lt", {g, q, l}, 0);
      chk("t5 nbits", {nb[1], nb[0]}, {6'd9, 6'd9});
      idle(5);
      // async reset between edges mid-run
      start = 1'b1; a_in = 32'd1; b_in = 32'd0;
      tick();
      start = 1'b0;
      repeat (5) tick();
      #2 reset = 1'b1;
      #1;
      chk("t6 busy", bsy, 0);
      chk("t6 done", dn, 0);
      chk("t6 gt/eq/lt", {g, q, l}, 0);
      chk("t6 nbits", {nb[1], nb[0]}, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      op(32'd1, 32'd0, 1, 33, 32, 3'b100, "t6 after reset");
      // random traffic: equal, shared-prefix and unrelated operands with sporadic aborts
      for (int i = 0; i < 3000; i++) begin
         start = ($urandom % 3) == 0;
         abort = ($urandom % 50) == 0;
         a_in = $urandom;
         case ($urandom_range(0, 2))
            0: b_in = a_in;
            1: b_in = a_in ^ ($urandom >> $urandom_range(0, 31));
            default: b_in = $urandom;
         endcase
         tick();
      end
      idle(40);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
